// File: rtl/merge2_arb.sv
// rtl/merge2_arb.sv - two-source round-robin merger into a one-entry registered output
// Counts accepted words per source with saturating counters.
module merge2_arb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_src_q,   out_src_d;
  logic              last_q,      last_d;
  logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,      cnt1_d;

  logic space;
  logic grant_vld;
  logic grant_src;
  logic take;

  // Round robin only matters when both compete; a lone requester always wins.
  always_comb begin
    grant_vld = in0_valid | in1_valid;
    grant_src = 1'b0;
    if (in0_valid && in1_valid) begin
      grant_src = ~last_q;
    end else if (in1_valid) begin
      grant_src = 1'b1;
    end
  end

  assign space     = ~out_valid_q | out_ready;
  assign take      = rst_n & space & grant_vld;
  assign in0_ready = take & ~grant_src;
  assign in1_ready = take & grant_src;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_src ? in1_data : in0_data;
      out_src_d   = grant_src;
      last_d      = grant_src;
      if (grant_src) begin
        cnt1_d = (&cnt1_q) ? cnt1_q : cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = (&cnt0_q) ? cnt0_q : cnt0_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // last resets to 1 so the first contested grant after reset goes to source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_merge2_arb.sv
// tb/tb_merge2_arb.sv - self-checking bench for merge2_arb with a transaction-level model
module tb_merge2_arb;

  logic        clk;
  logic        rst_n;
  logic        in0_valid, in1_valid, out_ready;
  logic [31:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, out_src;
  logic [31:0] out_data;
  logic [15:0] cnt0, cnt1;

  logic        d2_in0_ready, d2_in1_ready, d2_out_valid, d2_out_src;
  logic [31:0] d2_out_data;
  logic [1:0]  d2_cnt0, d2_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the sink should see and who was served last.
  int          m_valid, m_src, m_last, m_cnt0, m_cnt1;
  logic [31:0] m_data;

  merge2_arb #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  merge2_arb #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(d2_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(d2_in1_ready),
    .out_valid(d2_out_valid), .out_data(d2_out_data), .out_src(d2_out_src),
    .out_ready(out_ready), .cnt0(d2_cnt0), .cnt1(d2_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (in0_valid && in1_valid) return 1 - m_last;
    if (in0_valid) return 0;
    if (in1_valid) return 1;
    return -1;
  endfunction

  function automatic logic exp_rdy(int n);
    return rst_n && (m_valid == 0 || out_ready) && exp_grant() == n;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_data = '0;
  endtask

  task automatic model_edge();
    int g;
    g = exp_grant();
    if ((m_valid == 0 || out_ready) && g >= 0) begin
      m_valid = 1;
      m_src   = g;
      m_last  = g;
      m_data  = (g == 1) ? in1_data : in0_data;
      if (g == 0) m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
      else        m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b%b want 00", in0_ready, in1_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 1'b0) begin
      n_fail++; $display("FAIL reset_out got v=%b d=%h s=%b want 0/0/0", out_valid, out_data, out_src);
    end
    n_tests++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    in0_valid = 1'b1; in0_data = 32'h11111111; in1_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready got %b%b want 10", in0_ready, in1_ready);
    end
    cycle();
    in0_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h11111111 || out_src !== 1'b0 || cnt0 !== 16'd1) begin
      n_fail++; $display("FAIL single_out got v=%b d=%h s=%b c0=%0d want 1/11111111/0/1",
                         out_valid, out_data, out_src, cnt0);
    end
  endtask

  task automatic test_round_robin();
    int a = 0, b = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in0_valid = 1'b1; in0_data = 32'hA0000000 + a;
      in1_valid = 1'b1; in1_data = 32'hB0000000 + b;
      #1;
      n_tests++;
      if (in0_ready !== (i % 2 == 0) || in1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL rr_ready[%0d] got %b%b want src %0d", i, in0_ready, in1_ready, i % 2);
      end
      cycle();
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_src !== 1'(i % 2) ||
          out_data !== ((i % 2 == 0) ? 32'hA0000000 + a : 32'hB0000000 + b)) begin
        n_fail++; $display("FAIL rr_out[%0d] got v=%b s=%b d=%h want src %0d", i, out_valid, out_src, out_data, i % 2);
      end
      if (i % 2 == 0) a++; else b++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_tests++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd3) begin
      n_fail++; $display("FAIL rr_cnt got %0d/%0d want 3/3", cnt0, cnt1);
    end
  endtask

  task automatic test_stall();
    in0_valid = 1'b1; in0_data = 32'hDEADBEEF; in1_valid = 1'b0; out_ready = 1'b1;
    #1;
    cycle();
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 32'h0C0C0C0C;
    in1_valid = 1'b1; in1_data = 32'h1C1C1C1C;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL stall[%0d] got rdy=%b%b v=%b d=%h want 00/1/deadbeef",
                           i, in0_ready, in1_ready, out_valid, out_data);
      end
      cycle();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready got %b%b want 01", in0_ready, in1_ready);
    end
    cycle();
    in1_valid = 1'b0; in0_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h1C1C1C1C || out_src !== 1'b1) begin
      n_fail++; $display("FAIL stall_reload got v=%b d=%h s=%b want 1/1c1c1c1c/1", out_valid, out_data, out_src);
    end
    cycle();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h1C1C1C1C || out_src !== 1'b1) begin
      n_fail++; $display("FAIL drain_hold got v=%b d=%h s=%b want 0/1c1c1c1c/1", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_only_src1();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 32'h51510000 + i;
      #1;
      n_tests++;
      if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
        n_fail++; $display("FAIL only1_ready[%0d] got %b%b want 01", i, in0_ready, in1_ready);
      end
      cycle();
      #1;
      n_tests++;
      if (out_src !== 1'b1 || out_data !== 32'h51510000 + i) begin
        n_fail++; $display("FAIL only1_out[%0d] got s=%b d=%h want 1/%h", i, out_src, out_data, 32'h51510000 + i);
      end
    end
    in0_valid = 1'b1; in0_data = 32'h0F0F0F0F; in1_valid = 1'b1; in1_data = 32'h1F1F1F1F;
    #1;
    n_tests++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      n_fail++; $display("FAIL only1_then_both got %b%b want 10", in0_ready, in1_ready);
    end
    cycle();
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 32'h55555555; in1_valid = 1'b0;
    #1;
    cycle();
    out_ready = 1'b0; in1_valid = 1'b1; in1_data = 32'h66666666;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got v=%b c=%0d/%0d d=%h want 0/0/0/0", out_valid, cnt0, cnt1, out_data);
    end
    n_tests++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_ready got %b%b want 00", in0_ready, in1_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in0_data = 32'h77777777;
    #1;
    n_tests++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_grant got %b%b want 10", in0_ready, in1_ready);
    end
    cycle();
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    out_ready = 1'b1; in1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in0_valid = 1'b1; in0_data = 32'h00C00000 + i;
      #1;
      cycle();
      #1;
      want = (i + 1 < 3) ? i + 1 : 3;
      n_tests++;
      if (d2_cnt0 !== 2'(want) || d2_cnt1 !== 2'd0) begin
        n_fail++; $display("FAIL sat[%0d] got %0d/%0d want %0d/0", i, d2_cnt0, d2_cnt1, want);
      end
    end
    in0_valid = 1'b0;
  endtask

  task automatic test_random();
    logic acc0, acc1;
    do_reset();
    acc0 = 1'b1; acc1 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!in0_valid || acc0) begin
        in0_valid = ($urandom_range(0, 3) != 0);
        in0_data  = $urandom;
      end
      if (!in1_valid || acc1) begin
        in1_valid = ($urandom_range(0, 3) != 0);
        in1_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_tests++;
      if (in0_ready !== exp_rdy(0) || in1_ready !== exp_rdy(1)) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %b%b want %b%b", i, in0_ready, in1_ready, exp_rdy(0), exp_rdy(1));
      end
      n_tests++;
      if (out_valid !== (m_valid != 0) || (m_valid != 0 && (out_data !== m_data || out_src !== 1'(m_src)))) begin
        n_fail++; $display("FAIL rand_out[%0d] got v=%b d=%h s=%b want v=%0d d=%h s=%0d",
                           i, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
      n_tests++;
      if (cnt0 !== 16'(m_cnt0) || cnt1 !== 16'(m_cnt1) ||
          d2_cnt0 !== 2'((m_cnt0 < 3) ? m_cnt0 : 3) || d2_cnt1 !== 2'((m_cnt1 < 3) ? m_cnt1 : 3)) begin
        n_fail++; $display("FAIL rand_cnt[%0d] got %0d/%0d sat %0d/%0d want %0d/%0d",
                           i, cnt0, cnt1, d2_cnt0, d2_cnt1, m_cnt0, m_cnt1);
      end
      acc0 = in0_valid && exp_rdy(0);
      acc1 = in1_valid && exp_rdy(1);
      cycle();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_only_src1();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
